// File: rtl/ram_stream_pkg.sv
// Shared types and constants for the RAM stream reader.
// Holds the controller state encoding and the latency-absorbing buffer depth.
package ram_stream_pkg;

    localparam int unsigned BUF_DEPTH = 4;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        DRAIN,
        DONE
    } rsr_state_e;

endpackage

// File: rtl/ram_stream_buf.sv
// Small synchronous FIFO that absorbs RAM read latency in front of the stream output.
// The head entry drives the stream directly; reset flushes all entries.
module ram_stream_buf #(
    parameter  int unsigned WIDTH = 32,
    parameter  int unsigned DEPTH = 4,
    localparam int unsigned PW    = $clog2(DEPTH),
    localparam int unsigned OW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             push_last,
    output logic             valid,
    input  logic             ready,
    output logic [WIDTH-1:0] data,
    output logic             last,
    output logic [OW-1:0]    occupancy
);

    logic [DEPTH-1:0][WIDTH-1:0] mem_data;
    logic [DEPTH-1:0]            mem_last;
    logic [PW-1:0]               wr_ptr;
    logic [PW-1:0]               rd_ptr;
    logic                        pop;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] ptr);
        return (ptr == PW'(DEPTH - 1)) ? '0 : ptr + PW'(1);
    endfunction

    assign valid = (occupancy != '0);
    assign pop   = valid && ready;
    assign data  = mem_data[rd_ptr];
    assign last  = mem_last[rd_ptr];

    // Storage, pointers and fill level
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_data  <= '0;
            mem_last  <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            occupancy <= '0;
        end else begin
            if (push) begin
                mem_data[wr_ptr] <= push_data;
                mem_last[wr_ptr] <= push_last;
                wr_ptr           <= next_ptr(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            case ({push, pop})
                2'b10:   occupancy <= occupancy + OW'(1);
                2'b01:   occupancy <= occupancy - OW'(1);
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/ram_stream_reader.sv
// Burst read controller: walks a wrapping address range on a 1-cycle-latency RAM
// and presents the words as a valid/ready stream with a last marker.
module ram_stream_reader
    import ram_stream_pkg::*;
#(
    parameter  int unsigned WIDTH_DATA = 32,
    parameter  int unsigned NUMWORDS   = 256,
    localparam int unsigned AW         = $clog2(NUMWORDS),
    localparam int unsigned LW         = $clog2(NUMWORDS + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [AW-1:0]         start_addr,
    input  logic [LW-1:0]         length,
    output logic                  busy,
    output logic                  done,
    output logic                  rd_en,
    output logic [AW-1:0]         rd_addr,
    input  logic [WIDTH_DATA-1:0] rd_data,
    output logic                  m_valid,
    output logic [WIDTH_DATA-1:0] m_data,
    output logic                  m_last,
    input  logic                  m_ready
);

    localparam int unsigned OW = $clog2(BUF_DEPTH + 1);
    localparam int unsigned SW = OW + 1;

    rsr_state_e      state;
    rsr_state_e      state_next;
    logic [LW-1:0]   remaining;
    logic [1:0]      in_flight;
    logic            rd_pend;
    logic            last_pend;
    logic [OW-1:0]   occupancy;
    logic            credit_c;
    logic            issue_c;

    // Only issue when the read is guaranteed a buffer slot on arrival
    assign credit_c = (SW'(in_flight) + SW'(occupancy)) < SW'(BUF_DEPTH);
    assign rd_en    = issue_c;

    always_comb begin
        state_next = state;
        issue_c    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = (length == '0) ? DONE : READ;
                end
            end
            READ: begin
                issue_c = (remaining != '0) && credit_c;
                if (issue_c && (remaining == LW'(1))) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (m_valid && m_ready && m_last) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_next;
            busy  <= (state_next != IDLE);
            done  <= (state_next == DONE);
        end
    end

    // Address/remaining counters and the one-cycle RAM read pipeline tag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_addr   <= '0;
            remaining <= '0;
            in_flight <= '0;
            rd_pend   <= 1'b0;
            last_pend <= 1'b0;
        end else begin
            rd_pend   <= issue_c;
            last_pend <= issue_c && (remaining == LW'(1));
            if ((state == IDLE) && start) begin
                rd_addr   <= start_addr;
                remaining <= length;
            end else if (issue_c) begin
                rd_addr   <= (rd_addr == AW'(NUMWORDS - 1)) ? '0 : rd_addr + AW'(1);
                remaining <= remaining - LW'(1);
            end
            case ({issue_c, rd_pend})
                2'b10:   in_flight <= in_flight + 2'd1;
                2'b01:   in_flight <= in_flight - 2'd1;
                default: ;
            endcase
        end
    end

    ram_stream_buf #(
        .WIDTH (WIDTH_DATA),
        .DEPTH (BUF_DEPTH)
    ) u_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (rd_pend),
        .push_data (rd_data),
        .push_last (last_pend),
        .valid     (m_valid),
        .ready     (m_ready),
        .data      (m_data),
        .last      (m_last),
        .occupancy (occupancy)
    );

endmodule
